gf_div_seq: RTL and testbench
=============================

Name: gf_div_seq

Overview:
- Sequential GF(2^N) divider: out = a / b = a · b^(2^N−2) mod prim.
- Inverse-direction companion to the combinational GF multiplier. Used by the RS/BCH decoder datapath (error-value evaluation, normalisation).
- Square-and-multiply over N−1 iterations, one iteration per clock, start/busy/done handshake.

Parameters:
- N, 8, field degree; operand and result width.
- PRIM_DEFAULT, 9'h11D, documentation/bench default polynomial. The live polynomial comes from the prim port.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- a  input  N  dividend; sampled on accepting edge
- b  input  N  divisor; sampled on accepting edge
- prim  input  N+1  primitive polynomial, MSB = 1; sampled on accepting edge
- busy  output  1  high from accepting edge until done edge, inclusive of DONE state
- done  output  1  one-cycle pulse; out is valid from this cycle
- out  output  N  quotient; held until next accepted start
- div_by_zero  output  1  set with done when b == 0; held with out

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, out=0, div_by_zero=0, all internal registers 0.
- Reset mid-operation aborts immediately. No done is produced for the aborted request.
- State IDLE:
  - start=1 captures a, b, prim into registers: acc←a, sq←b, cnt←0.
  - If b==0: next state is ZERO. Otherwise next state is RUN.
  - start=0: remain in IDLE.
- State RUN, one iteration per cycle, for cnt = 0..N−2:
  - sq ← sq² mod prim
  - acc ← acc · (sq² mod prim) mod prim
  - cnt ← cnt+1
  - After cnt reaches N−2, next state is DONE.
  - Two combinational multiply-reduce instances per cycle; the second uses the first's output.
- State ZERO: next state is DONE with acc←0 and div_by_zero flag staged to 1.
- State DONE:
  - out←acc, div_by_zero←staged flag, done=1 for exactly this cycle.
  - Returns to IDLE next cycle.
- Latency: the accepting edge is edge 0. done is high in the cycle after edge N (b≠0) or after edge 2 (b==0).
- start while busy is ignored, not queued.
- start in the DONE cycle is ignored; a new start is accepted in IDLE only.
- Arithmetic and width rules:
  - All operations are carry-less.
  - Products are 2N−1 bits, reduced MSB-first by XOR of prim aligned at each set bit from 2N−2 down to N.
  - The result is the low N bits.
- a==0 with b≠0 yields out=0, div_by_zero=0, normal latency.
- prim is not checked for irreducibility. Results are undefined (but deterministic) for a reducible prim.
- out and div_by_zero change only in the DONE cycle.

Optional Feature:
- Macro: GF_DIV_UNIT_SHORTCUT_EN.
- Defined: b==1 at accept bypasses RUN and goes IDLE→DONE with out=a. done is high in the cycle after edge 1.
- Undefined: b==1 takes the full N-cycle path (same result, normal latency).

Decomposition:
- Shared package gf_pkg holds:
  - GF_N default (8)
  - GF_PRIM_RS (9'h11D) and GF_PRIM_AES (9'h11B)
  - state enum {IDLE, RUN, ZERO, DONE}
  - counter width $clog2(N)
- One sub-module: gf_mulred.
  - Purely combinational N×N carry-less multiply plus reduction, ports a, b, prim, out.
  - Instantiated twice: square, and accumulate.

Test Plan:
- prim=9'h11D, a=8'h01, b=8'h02, pulse start → done in the cycle after edge 8; out=8'h8E, div_by_zero=0.
- prim=9'h11B, a=8'h01, b=8'h53 → out=8'hCA. Then a=8'hC1, b=8'h83 → out=8'h57.
- prim=9'h11D, a=8'h37, b=8'h00 → done in the cycle after edge 2; out=8'h00, div_by_zero=1. Next request with b=8'h02 clears div_by_zero.
- Start pulsed again on edges 1..7 of a running request → ignored. Exactly one done; out matches the first operands; busy continuous.
- rst asserted asynchronously mid-RUN (between edges 4 and 5) → busy=0, done=0, out=0 immediately, no done later. A fresh request with a=8'h8E, b=8'h8E then yields out=8'h01.
- Randomised 1000 pairs, b≠0, prim 9'h11D: gf_mulred(out, b) == a. Also test both with and without GF_DIV_UNIT_SHORTCUT_EN: b=8'h01, a=8'hA5 → out=8'hA5, with latency 1 or 8 respectively.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared GF(2^N) definitions: default field degree, standard primitive
// polynomials and the divider state encoding.
package gf_pkg;

  localparam int GF_N = 8;
  localparam logic [8:0] GF_PRIM_RS  = 9'h11D;
  localparam logic [8:0] GF_PRIM_AES = 9'h11B;
  localparam int GF_CNT_W = $clog2(GF_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } gf_state_e;

endpackage

// File: rtl/gf_div_seq_if.sv
// Request/response bundle of the sequential GF divider.
interface gf_div_seq_if #(
  parameter int N = 8
);

  // Handshake: start is a request taken only while busy is low; operands are
  // sampled on that edge. busy stays high until the edge that raises done, a
  // one-cycle pulse from which out/div_by_zero are valid and then held.
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   prim;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         div_by_zero;

  modport master (
    output start, a, b, prim,
    input  busy, done, out, div_by_zero
  );

  modport slave (
    input  start, a, b, prim,
    output busy, done, out, div_by_zero
  );

endinterface

// File: rtl/gf_mulred.sv
// Combinational N x N carry-less multiply followed by MSB-first reduction
// modulo prim; the result is the low N bits of the reduced product.
module gf_mulred #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N:0]   prim,
  output logic [N-1:0] out
);

  logic [2*N-2:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) prod = prod ^ ({{(N-1){1'b0}}, a} << i);
    end
    // Clearing bit j with prim's leading 1 can only set lower bits, so a
    // single descending pass leaves a fully reduced value.
    for (int j = 2*N-2; j >= N; j--) begin
      if (prod[j]) prod = prod ^ ({{(N-2){1'b0}}, prim} << (j-N));
    end
    out = prod[N-1:0];
  end

endmodule

// File: rtl/gf_div_seq.sv
// Sequential GF(2^N) divider: out = a * b^(2^N-2) mod prim by square-and-multiply.
// Define GF_DIV_UNIT_SHORTCUT_EN to send b==1 straight to DONE with out=a.
module gf_div_seq
  import gf_pkg::*;
#(
  parameter int         N            = GF_N,
  parameter logic [N:0] PRIM_DEFAULT = (N+1)'(GF_PRIM_RS)
) (
  input  logic       clk,
  input  logic       rst,
  gf_div_seq_if.slave bus,
  output gf_state_e  dbg_state
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

  if (PRIM_DEFAULT[N] != 1'b1) begin : g_bad_prim
    $error("PRIM_DEFAULT must have its degree-N bit set");
  end

  gf_state_e        state, state_n;
  logic [N-1:0]     acc, sq, sq2, prod;
  logic [N:0]       prim_r;
  logic [CNT_W-1:0] cnt;
  logic             dz_stage;
  logic             done_r, dz_r;
  logic [N-1:0]     out_r;
  logic             accept;

  gf_mulred #(.N(N)) u_square (
    .a    (sq),
    .b    (sq),
    .prim (prim_r),
    .out  (sq2)
  );

  // Multiplies by the freshly squared value, so iteration k folds in b^(2^(k+1)).
  gf_mulred #(.N(N)) u_accum (
    .a    (acc),
    .b    (sq2),
    .prim (prim_r),
    .out  (prod)
  );

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.b == '0) state_n = ZERO;
`ifdef GF_DIV_UNIT_SHORTCUT_EN
          else if (bus.b == N'(1)) state_n = DONE;
`endif
          else state_n = RUN;
        end
      end
      RUN:     if (cnt == CNT_W'(N-2)) state_n = DONE;
      ZERO:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sq       <= '0;
      prim_r   <= '0;
      cnt      <= '0;
      dz_stage <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      out_r    <= '0;
    end else begin
      done_r <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= bus.a;
            sq       <= bus.b;
            prim_r   <= bus.prim;
            cnt      <= '0;
            dz_stage <= 1'b0;
          end
        end
        RUN: begin
          sq  <= sq2;
          acc <= prod;
          cnt <= cnt + 1'b1;
        end
        ZERO: begin
          acc      <= '0;
          dz_stage <= 1'b1;
        end
        DONE: begin
          out_r <= acc;
          dz_r  <= dz_stage;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.out         = out_r;
  assign bus.div_by_zero = dz_r;
  assign dbg_state       = state;

endmodule

// File: tb/tb_gf_div_seq.sv
// Directed bench for gf_div_seq: table of hand-computed quotients, handshake
// corner sequences (start while busy, async abort) and a randomised inverse check.
module tb_gf_div_seq;
  import gf_pkg::*;

`ifdef GF_DIV_UNIT_SHORTCUT_EN
  localparam int UNIT_LAT = 1;
`else
  localparam int UNIT_LAT = 8;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] prim;
    logic [7:0] exp_out;
    logic       exp_dz;
    int         exp_lat;
  } vec_t;

  logic      clk;
  logic      rst;
  gf_state_e dbg_state;
  int        checks;
  int        errors;
  logic [7:0] exp_q[$];
  logic [7:0] held_exp;

  gf_div_seq_if #(.N(8)) bus ();

  gf_div_seq #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul_model(input logic [7:0] x, input logic [7:0] y,
                                               input logic [8:0] p);
    logic [7:0] r;
    logic [7:0] t;
    r = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ p[7:0]) : (t << 1);
    end
    return r;
  endfunction

  // driver: one request, waits (bounded) for done
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [8:0] p,
                         output logic [7:0] got, output logic got_dz, output int lat,
                         output logic busy_ok, output logic held_ok, output logic pulse_ok);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.prim  = p;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat      = 0;
    got      = 'x;
    got_dz   = 1'bx;
    busy_ok  = 1'b1;
    held_ok  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat    = k;
        got    = bus.out;
        got_dz = bus.div_by_zero;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.out !== held_exp) held_ok = 1'b0;
    end
    @(posedge clk);
    #1;
    pulse_ok = !bus.done;
  endtask

  initial begin
    vec_t       vecs[9];
    logic [7:0] got, exp;
    logic       got_dz, busy_ok, held_ok, pulse_ok;
    int         lat, n_done, done_edge, busy_gap;
    logic [7:0] ra, rb;

    vecs[0] = '{8'h01, 8'h02, 9'h11D, 8'h8E, 1'b0, 8};
    vecs[1] = '{8'h01, 8'h53, 9'h11B, 8'hCA, 1'b0, 8};
    vecs[2] = '{8'hC1, 8'h83, 9'h11B, 8'h57, 1'b0, 8};
    vecs[3] = '{8'h37, 8'h00, 9'h11D, 8'h00, 1'b1, 2};
    vecs[4] = '{8'h01, 8'h02, 9'h11D, 8'h8E, 1'b0, 8};
    vecs[5] = '{8'h00, 8'h05, 9'h11D, 8'h00, 1'b0, 8};
    vecs[6] = '{8'h8E, 8'h8E, 9'h11D, 8'h01, 1'b0, 8};
    vecs[7] = '{8'h01, 8'h8E, 9'h11D, 8'h02, 1'b0, 8};
    vecs[8] = '{8'hA5, 8'h01, 9'h11D, 8'hA5, 1'b0, UNIT_LAT};

    checks    = 0;
    errors    = 0;
    held_exp  = 8'h00;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.prim  = 9'h11D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    check("reset dz", 32'(bus.div_by_zero), 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // table-driven vectors
    for (int v = 0; v < 9; v++) begin
      exp_q.push_back(vecs[v].exp_out);
      run_one(vecs[v].a, vecs[v].b, vecs[v].prim, got, got_dz, lat, busy_ok, held_ok, pulse_ok);
      exp = exp_q.pop_front();
      check($sformatf("vec%0d out", v), 32'(got), 32'(exp));
      check($sformatf("vec%0d dz", v), 32'(got_dz), 32'(vecs[v].exp_dz));
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("vec%0d busy", v), 32'(busy_ok), 32'd1);
      check($sformatf("vec%0d out held", v), 32'(held_ok), 32'd1);
      check($sformatf("vec%0d one-cycle done", v), 32'(pulse_ok), 32'd1);
      held_exp = exp;
    end

    // start held high on edges 1..7 of a running request must be ignored
    @(negedge clk);
    bus.a = 8'h01; bus.b = 8'h02; bus.prim = 9'h11D; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h55; bus.b = 8'h77;
    n_done = 0; done_edge = 0; busy_gap = 0; got = 'x;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e <= 7 && !bus.busy) busy_gap++;
      if (bus.done) begin
        n_done++;
        done_edge = e;
        got = bus.out;
      end
      if (e == 7) bus.start = 1'b0;
    end
    check("busy-start done count", 32'(n_done), 32'd1);
    check("busy-start done edge", 32'(done_edge), 32'd8);
    check("busy-start out", 32'(got), 32'h8E);
    check("busy-start busy gaps", 32'(busy_gap), 32'd0);

    // asynchronous reset between edges 4 and 5 aborts the request
    @(negedge clk);
    bus.a = 8'h01; bus.b = 8'h02; bus.prim = 9'h11D; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort out", 32'(bus.out), 32'd0);
    check("abort state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("abort no done", 32'(n_done), 32'd0);
    held_exp = 8'h00;
    run_one(8'h8E, 8'h8E, 9'h11D, got, got_dz, lat, busy_ok, held_ok, pulse_ok);
    check("post-abort out", 32'(got), 32'h01);
    check("post-abort latency", 32'(lat), 32'd8);
    check("post-abort out held", 32'(held_ok), 32'd1);
    held_exp = 8'h01;

    // randomised: quotient times divisor must give the dividend back
    for (int r = 0; r < 1000; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      run_one(ra, rb, 9'h11D, got, got_dz, lat, busy_ok, held_ok, pulse_ok);
      check($sformatf("rand a=%0h b=%0h q*b", ra, rb), 32'(gf_mul_model(got, rb, 9'h11D)),
            32'(ra));
      held_exp = got;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
